// File: rtl/cmd_pkg.sv
// Shared constants, state encodings and helpers
// for the host command engine.
package cmd_pkg;

  localparam logic [7:0] OP_ID     = 8'h49;
  localparam logic [7:0] OP_SET_A  = 8'h41;
  localparam logic [7:0] OP_GET_A  = 8'h61;
  localparam logic [7:0] OP_SET_B  = 8'h42;
  localparam logic [7:0] OP_GET_B  = 8'h62;
  localparam logic [7:0] OP_GET_F  = 8'h73;
  localparam logic [7:0] OP_FLOAT  = 8'h66;
  localparam logic [7:0] OP_OFF_CW = 8'h4F;
  localparam logic [7:0] OP_SET_CW = 8'h4D;
  localparam logic [7:0] OP_CLK    = 8'h63;
  localparam logic [7:0] OP_ICLK   = 8'h43;
  localparam logic [7:0] OP_TICK   = 8'h54;
  localparam logic [7:0] OP_RD_MEM = 8'h72;
  localparam logic [7:0] OP_BRK    = 8'h52;
  localparam logic [7:0] OP_NOP    = 8'h4E;
  localparam logic [7:0] OP_NOP_FF = 8'hFF;
  localparam logic [7:0] OP_HALT   = 8'h51;
  localparam logic [7:0] RSP_UNK   = 8'h3F;

  localparam int ID_LEN  = 9;
  localparam int BRK_LEN = 4;
  localparam logic [8*ID_LEN-1:0]  ID_STR  = "VerilogVM";
  localparam logic [8*BRK_LEN-1:0] BRK_STR = "#BRK";

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_EXEC,
    ST_PULSE,
    ST_TX
  } state_t;

  typedef enum logic [1:0] {
    PM_CLK,
    PM_ICLK,
    PM_BOTH
  } pmode_t;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_HI1,
    PS_LOW,
    PS_HI2
  } pstate_t;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmd_pulse_seq.sv
// CPU clock pulse sequencer: single clk, single iclk,
// or clk-gap-iclk, each phase PULSE_CYC cycles wide.
module cmd_pulse_seq
  import cmd_pkg::*;
#(
  parameter int PULSE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       cpu_clk,
  output logic       cpu_iclk,
  output logic       done
);

  localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PULSE_CYC - 1);

  pstate_t          st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             clk_q, clk_d;
  logic             iclk_q, iclk_d;
  logic             ph_end;

  assign ph_end = (cnt_q == LAST);

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    done   = 1'b0;
    unique case (st_q)
      PS_IDLE: begin
        if (start) begin
          mode_d = mode;
          cnt_d  = '0;
          st_d   = (mode == PM_ICLK) ? PS_HI2 : PS_HI1;
        end
      end
      PS_HI1: begin
        if (ph_end) begin
          cnt_d = '0;
          if (mode_q == PM_BOTH) begin
            st_d = PS_LOW;
          end else begin
            st_d = PS_IDLE;
            done = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PS_LOW: begin
        if (ph_end) begin
          cnt_d = '0;
          st_d  = PS_HI2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PS_HI2: begin
        if (ph_end) begin
          cnt_d = '0;
          st_d  = PS_IDLE;
          done  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = PS_IDLE;
    endcase
    // Registered outputs keep the pulses glitch-free.
    clk_d  = (st_d == PS_HI1);
    iclk_d = (st_d == PS_HI2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= PS_IDLE;
      cnt_q  <= '0;
      mode_q <= '0;
      clk_q  <= 1'b0;
      iclk_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      clk_q  <= clk_d;
      iclk_q <= iclk_d;
    end
  end

  assign cpu_clk  = clk_q;
  assign cpu_iclk = iclk_q;

endmodule

// File: rtl/cmd_engine.sv
// Host command engine: byte-stream commands drive the
// CPU buses, control word and clocks; results stream back.
module cmd_engine
  import cmd_pkg::*;
#(
  parameter int              DATA_W      = 8,
  parameter int              ADDR_W      = 16,
  parameter int              CW_W        = 32,
  parameter int              FLAG_W      = 4,
  parameter logic [CW_W-1:0] CW_DEFAULT  = '0,
  parameter int              PULSE_CYC   = 1,
  parameter int              ARG_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_oe,
  output logic [CW_W-1:0]   control_word,
  output logic              cpu_clk,
  output logic              cpu_iclk,
  output logic              err,
  output logic              halted
);

  localparam int NB_D   = nbytes(DATA_W);
  localparam int NB_A   = nbytes(ADDR_W);
  localparam int NB_C   = nbytes(CW_W);
  localparam int NB_F   = nbytes(FLAG_W);
  localparam int ARG_NB = imax(imax(NB_A, NB_D), NB_C);
  localparam int RSP_N  = imax(imax(ID_LEN, BRK_LEN),
                               imax(imax(NB_A, NB_D), NB_F));
  localparam int AC_W   = $clog2(ARG_NB + 1);
  localparam int RI_W   = $clog2(RSP_N + 1);
  localparam int TM_W   = $clog2(ARG_TIMEOUT + 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(ARG_TIMEOUT - 1);

  state_t              st_q, st_d;
  logic [7:0]          op_q, op_d;
  logic [AC_W-1:0]     cnt_q, cnt_d;
  logic [TM_W-1:0]     tmr_q, tmr_d;
  logic [ARG_NB*8-1:0] arg_q, arg_d;
  logic [RSP_N*8-1:0]  rsp_q, rsp_d;
  logic [RI_W-1:0]     len_q, len_d;
  logic [RI_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                doe_q, doe_d;
  logic [ADDR_W-1:0]   aout_q, aout_d;
  logic                aoe_q, aoe_d;
  logic [CW_W-1:0]     cw_q, cw_d;
  logic                err_q, err_d;
  logic                halted_q, halted_d;

  logic                rx_fire;
  logic                p_start;
  logic [1:0]          p_mode;
  logic                p_done;
  logic [NB_A*8-1:0]   a_ext;
  logic [NB_D*8-1:0]   d_ext;
  logic [NB_F*8-1:0]   f_ext;

  function automatic logic [AC_W-1:0] arg_len(input logic [7:0] op);
    case (op)
      OP_SET_A:                       arg_len = AC_W'(NB_A);
      OP_SET_B:                       arg_len = AC_W'(NB_D);
      OP_OFF_CW, OP_SET_CW, OP_RD_MEM: arg_len = AC_W'(NB_C);
      default:                        arg_len = '0;
    endcase
  endfunction

  always_comb begin
    a_ext = '0;
    d_ext = '0;
    f_ext = '0;
    a_ext[ADDR_W-1:0] = addr_in;
    d_ext[DATA_W-1:0] = bus_in;
    f_ext[FLAG_W-1:0] = flags_in;
  end

  assign rx_ready = ((st_q == ST_IDLE) && !halted_q) || (st_q == ST_ARG);
  assign rx_fire  = rx_valid && rx_ready;
  assign tx_valid = (st_q == ST_TX);
  assign tx_data  = tx_valid ? rsp_q[8*idx_q +: 8] : 8'h00;

  always_comb begin
    st_d     = st_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    arg_d    = arg_q;
    rsp_d    = rsp_q;
    len_d    = len_q;
    idx_d    = idx_q;
    dout_d   = dout_q;
    doe_d    = doe_q;
    aout_d   = aout_q;
    aoe_d    = aoe_q;
    cw_d     = cw_q;
    err_d    = err_q;
    halted_d = halted_q;
    p_start  = 1'b0;
    p_mode   = PM_CLK;
    unique case (st_q)
      ST_IDLE: begin
        if (rx_fire) begin
          op_d  = rx_data;
          cnt_d = '0;
          tmr_d = '0;
          arg_d = '0;
          st_d  = (arg_len(rx_data) != '0) ? ST_ARG : ST_EXEC;
        end
      end
      ST_ARG: begin
        if (rx_fire) begin
          arg_d[8*cnt_q +: 8] = rx_data;
          tmr_d = '0;
          if ((cnt_q + 1'b1) == arg_len(op_q)) begin
            st_d = ST_EXEC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmr_q == TM_LAST) begin
          // Stalled host: drop the partial argument.
          st_d  = ST_IDLE;
          err_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_EXEC: begin
        st_d  = ST_IDLE;
        idx_d = '0;
        unique case (op_q)
          OP_ID: begin
            rsp_d = '0;
            for (int i = 0; i < ID_LEN; i++)
              rsp_d[8*i +: 8] = ID_STR[8*(ID_LEN-1-i) +: 8];
            len_d = RI_W'(ID_LEN);
            st_d  = ST_TX;
          end
          OP_SET_A: begin
            aout_d = arg_q[ADDR_W-1:0];
            aoe_d  = 1'b1;
          end
          OP_GET_A: begin
            rsp_d = '0;
            rsp_d[NB_A*8-1:0] = a_ext;
            len_d = RI_W'(NB_A);
            st_d  = ST_TX;
          end
          OP_SET_B: begin
            dout_d = arg_q[DATA_W-1:0];
            doe_d  = 1'b1;
          end
          OP_GET_B: begin
            rsp_d = '0;
            rsp_d[NB_D*8-1:0] = d_ext;
            len_d = RI_W'(NB_D);
            st_d  = ST_TX;
          end
          OP_GET_F: begin
            rsp_d = '0;
            rsp_d[NB_F*8-1:0] = f_ext;
            len_d = RI_W'(NB_F);
            st_d  = ST_TX;
          end
          OP_FLOAT: begin
            doe_d = 1'b0;
            aoe_d = 1'b0;
          end
          OP_OFF_CW: begin
            doe_d = 1'b0;
            aoe_d = 1'b0;
            cw_d  = arg_q[CW_W-1:0];
          end
          OP_SET_CW: cw_d = arg_q[CW_W-1:0];
          OP_CLK: begin
            p_start = 1'b1;
            p_mode  = PM_CLK;
            st_d    = ST_PULSE;
          end
          OP_ICLK: begin
            p_start = 1'b1;
            p_mode  = PM_ICLK;
            st_d    = ST_PULSE;
          end
          OP_TICK: begin
            p_start = 1'b1;
            p_mode  = PM_BOTH;
            st_d    = ST_PULSE;
          end
          OP_RD_MEM: begin
            rsp_d = '0;
            len_d = RI_W'(NB_D);
            st_d  = ST_TX;
          end
          OP_BRK: begin
            rsp_d = '0;
            for (int i = 0; i < BRK_LEN; i++)
              rsp_d[8*i +: 8] = BRK_STR[8*(BRK_LEN-1-i) +: 8];
            len_d = RI_W'(BRK_LEN);
            st_d  = ST_TX;
          end
          OP_NOP, OP_NOP_FF: ;
          OP_HALT: halted_d = 1'b1;
          default: begin
            err_d = 1'b1;
            rsp_d = '0;
            rsp_d[7:0] = RSP_UNK;
            len_d = RI_W'(1);
            st_d  = ST_TX;
          end
        endcase
      end
      ST_PULSE: begin
        if (p_done) st_d = ST_IDLE;
      end
      ST_TX: begin
        if (tx_ready) begin
          if ((idx_q + 1'b1) == len_q) begin
            st_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= ST_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      arg_q    <= '0;
      rsp_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      dout_q   <= '0;
      doe_q    <= 1'b0;
      aout_q   <= '0;
      aoe_q    <= 1'b0;
      cw_q     <= CW_DEFAULT;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      st_q     <= st_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      arg_q    <= arg_d;
      rsp_q    <= rsp_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      dout_q   <= dout_d;
      doe_q    <= doe_d;
      aout_q   <= aout_d;
      aoe_q    <= aoe_d;
      cw_q     <= cw_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  cmd_pulse_seq #(
    .PULSE_CYC(PULSE_CYC)
  ) u_pulse (
    .clk     (clk),
    .rst     (rst),
    .start   (p_start),
    .mode    (p_mode),
    .cpu_clk (cpu_clk),
    .cpu_iclk(cpu_iclk),
    .done    (p_done)
  );

  assign data_out     = dout_q;
  assign data_oe      = doe_q;
  assign addr_out     = aout_q;
  assign addr_oe      = aoe_q;
  assign control_word = cw_q;
  assign err          = err_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_cmd_engine.sv
// Scoreboard bench for cmd_engine: expected tx bytes are
// queued at command issue and popped on each handshake.
module tb_cmd_engine;

  localparam logic [31:0] CW_DEF = 32'h0000_00A5;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  bus_in;
  logic [15:0] addr_in;
  logic [3:0]  flags_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [15:0] addr_out;
  logic        addr_oe;
  logic [31:0] control_word;
  logic        cpu_clk;
  logic        cpu_iclk;
  logic        err;
  logic        halted;

  int         n_tests;
  int         n_fail;
  int         tx_mode;
  logic [7:0] exp_q[$];
  logic       prev_stall;
  logic [7:0] prev_data;

  cmd_engine #(
    .DATA_W     (8),
    .ADDR_W     (16),
    .CW_W       (32),
    .FLAG_W     (4),
    .CW_DEFAULT (CW_DEF),
    .PULSE_CYC  (2),
    .ARG_TIMEOUT(50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .bus_in      (bus_in),
    .addr_in     (addr_in),
    .flags_in    (flags_in),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .addr_out    (addr_out),
    .addr_oe     (addr_oe),
    .control_word(control_word),
    .cpu_clk     (cpu_clk),
    .cpu_iclk    (cpu_iclk),
    .err         (err),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign addr_in  = addr_oe ? addr_out : 16'h5A5A;
  assign bus_in   = data_oe ? data_out : 8'h3C;
  assign flags_in = 4'h9;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    logic ok;
    ok       = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (rx_ready) ok = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!ok) chk("rx_accept", 32'(b), 32'h100);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    chk("drain", exp_q.size(), 0);
    tick(2);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  initial begin
    tx_ready   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      case (tx_mode)
        0:       tx_ready = ~tx_ready;
        1:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
      #1;
      if (prev_stall && tx_valid) chk("tx_hold", tx_data, prev_data);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("tx_unexpected", tx_data, 32'h100);
        else chk("tx_byte", tx_data, exp_q.pop_front());
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    n_tests  = 0;
    n_fail   = 0;
    tx_mode  = 0;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(3);
    chk("rst_cw", control_word, CW_DEF);
    chk("rst_outs", {data_oe, addr_oe, err, halted,
                     cpu_clk, cpu_iclk, tx_valid}, 0);
    chk("rst_buses", {data_out, addr_out}, 0);
    rst = 1'b1;
    tick();
    chk("idle_rx_ready", rx_ready, 1);

    push_str("VerilogVM");
    send(8'h49);
    drain();

    send(8'h41); send(8'h34); send(8'h12);
    chk("A_latency", addr_oe, 0);
    tick();
    chk("A_oe", addr_oe, 1);
    chk("A_val", addr_out, 16'h1234);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    send(8'h61);
    drain();
    send(8'h66);
    tick(2);
    chk("f_oe", {data_oe, addr_oe}, 0);

    send(8'h42); send(8'h77);
    tick();
    chk("B_val", data_out, 8'h77);
    chk("B_oe", data_oe, 1);
    exp_q.push_back(8'h77);
    send(8'h62);
    drain();
    exp_q.push_back(8'h09);
    send(8'h73);
    drain();

    send(8'h41); send(8'h34); send(8'h12);
    tick();
    send(8'h4F); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("O_pre_cw", control_word, CW_DEF);
    chk("O_pre_oe", {data_oe, addr_oe}, 2'b11);
    tick();
    chk("O_cw", control_word, 32'hDEAD_BEEF);
    chk("O_oe", {data_oe, addr_oe}, 0);

    send(8'h54);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("T_clk%0d", k), cpu_clk, (k == 1 || k == 2));
      chk($sformatf("T_iclk%0d", k), cpu_iclk, (k == 5 || k == 6));
      tick();
    end
    send(8'h63);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("c_clk%0d", k), {cpu_clk, cpu_iclk},
          (k == 1 || k == 2) ? 2'b10 : 2'b00);
      tick();
    end
    send(8'h43);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("C_iclk%0d", k), {cpu_clk, cpu_iclk},
          (k == 1 || k == 2) ? 2'b01 : 2'b00);
      tick();
    end

    send(8'h4D); send(8'h01);
    tick(40);
    chk("tmo_early", err, 0);
    tick(20);
    chk("tmo_err", err, 1);
    chk("tmo_cw", control_word, 32'hDEAD_BEEF);
    send(8'h4E);
    tick(2);
    chk("nop_rx_ready", rx_ready, 1);
    chk("err_sticky", err, 1);

    exp_q.push_back(8'h3F);
    send(8'h7A);
    drain();
    exp_q.push_back(8'h00);
    send(8'h72); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    drain();
    chk("r_cw", control_word, 32'hDEAD_BEEF);
    send(8'h4D); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    tick();
    chk("M_cw", control_word, 32'h1234_5678);

    send(8'h42); send(8'hAA);
    tick();
    chk("B2_val", data_out, 8'hAA);
    tx_mode = 1;
    send(8'h52);
    tick(3);
    chk("R_valid", tx_valid, 1);
    chk("R_first", tx_data, 8'h23);
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_tx", {tx_valid, cpu_clk, cpu_iclk}, 0);
    chk("mid_rst_oe", {data_oe, addr_oe, err, halted}, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_cw", control_word, CW_DEF);
    tick(2);
    rst = 1'b1;
    tx_mode = 0;
    tick();

    send(8'h51);
    tick(2);
    chk("Q_halted", halted, 1);
    seen = 0;
    rx_data  = 8'h4E;
    rx_valid = 1'b1;
    repeat (10) begin
      #1;
      if (rx_ready) seen++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("Q_rx_ready", seen, 0);
    chk("Q_no_tx", tx_valid, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
